serial_add_ctrl: RTL and testbench

Bit-serial add/subtract controller that time-multiplexes one 1-bit full-adder cell over WIDTH-bit operands, one bit per clock, LSB first. It latches operands on a START request, runs the shared adder for WIDTH cycles with a registered carry, and returns the sum, carry-out and signed-overflow flag with a one-cycle DONE pulse. It is the area-minimal arithmetic path for ALU operations where latency is acceptable.

---
 rtl/serial_add_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial add/subtract controller. A single 1-bit full-adder cell is
//   reused for WIDTH clock cycles, LSB first, with the carry held in a
//   register between bits. Operands are latched on an accepted start
//   request. The sum, carry-out and signed-overflow flag are presented
//   with a one-cycle done pulse.
//
// Ports
//   clk_i     : clock, rising edge active
//   rst_ni    : asynchronous active-low reset
//   start_i   : operation request, sampled only while idle
//   sub_i     : 0 = a + b, 1 = a - b (latched with start)
//   a_i, b_i  : WIDTH-bit operands (latched with start)
//   busy_o    : high while the serial adder is running
//   done_o    : one-cycle pulse, result_o/co_o/v_o valid
//   result_o  : sum/difference, held until the next accepted start
//   co_o      : final carry out (for subtraction 1 = no borrow)
//   v_o       : signed overflow (carry into MSB xor carry out of MSB)

module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             co_o,
  output logic             v_o
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             co_q;
  logic             v_q;

  // The shared full-adder cell, always looking at the current LSBs and the
  // registered carry.
  logic sum_d;
  logic carry_d;

  always_comb begin
    sum_d   = opa_q[0] ^ opb_q[0] ^ carry_q;
    carry_d = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
  end

  // Controller and datapath. Subtraction is done as a + ~b + 1, so the
  // inverted operand and a carry-in of one are loaded at acceptance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            opa_q   <= a_i;
            opb_q   <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          res_q   <= {sum_d, res_q[WIDTH-1:1]};
          opa_q   <= {1'b0, opa_q[WIDTH-1:1]};
          opb_q   <= {1'b0, opb_q[WIDTH-1:1]};
          carry_q <= carry_d;
          cnt_q   <= cnt_q + 1'b1;
          // On the MSB, carry_q is the carry into the MSB, so overflow is
          // simply its difference from the carry out.
          if (cnt_q == LAST_BIT) begin
            co_q    <= carry_d;
            v_q     <= carry_q ^ carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = res_q;
  assign co_o     = co_q;
  assign v_o      = v_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Drives an 8-bit and a 32-bit instance of serial_add_ctrl. Directed
//   cases plus random operations are compared against an arithmetic
//   reference model that works on integer values rather than bits.

module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, co8, v8;
  logic [7:0]  res8;

  logic        start32 = 1'b0, sub32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, co32, v32;
  logic [31:0] res32;

  int vectorCount = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .sub_i(sub8),
    .a_i(a8), .b_i(b8), .busy_o(busy8), .done_o(done8),
    .result_o(res8), .co_o(co8), .v_o(v8)
  );

  serial_add_ctrl #(.WIDTH(32)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start32), .sub_i(sub32),
    .a_i(a32), .b_i(b32), .busy_o(busy32), .done_o(done32),
    .result_o(res32), .co_o(co32), .v_o(v32)
  );

  // Single point of comparison: counts every check and reports misses.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectorCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, output logic [31:0] r,
                                   output logic co, output logic v);
    longint modv, ua, ub, ures, sa, sb, sres;
    modv = longint'(1) <<< w;
    ua   = longint'(a);
    ub   = longint'(b);
    ures = sub ? (ua - ub) : (ua + ub);
    co   = sub ? (ua >= ub) : (ures >= modv);
    r    = 32'(((ures % modv) + modv) % modv);
    sa   = (ua >= modv / 2) ? ua - modv : ua;
    sb   = (ub >= modv / 2) ? ub - modv : ub;
    sres = sub ? (sa - sb) : (sa + sb);
    v    = (sres >= modv / 2) || (sres < -(modv / 2));
  endfunction

  function automatic logic obsBusy(input bit use32);
    return use32 ? busy32 : busy8;
  endfunction

  function automatic logic obsDone(input bit use32);
    return use32 ? done32 : done8;
  endfunction

  function automatic logic [31:0] obsResult(input bit use32);
    return use32 ? res32 : {24'd0, res8};
  endfunction

  function automatic logic obsCo(input bit use32);
    return use32 ? co32 : co8;
  endfunction

  function automatic logic obsV(input bit use32);
    return use32 ? v32 : v8;
  endfunction

  task automatic driveInputs(input bit use32, input logic start, input logic sub,
                             input logic [31:0] a, input logic [31:0] b);
    if (use32) begin
      start32 = start; sub32 = sub; a32 = a; b32 = b;
    end else begin
      start8 = start; sub8 = sub; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  // One full operation: request, then watch busy/done for the whole window,
  // scrambling the operand inputs after acceptance.
  task automatic applyStimulus(input bit use32, input logic [31:0] a, input logic [31:0] b,
                               input logic sub, input string tag,
                               output logic [31:0] gotR, output logic gotCo, output logic gotV);
    int w;
    int busyCnt;
    int doneCnt;
    int doneAt;
    int both;
    logic [31:0] er;
    logic eco, ev;
    w = use32 ? 32 : 8;
    busyCnt = 0; doneCnt = 0; doneAt = -1; both = 0;
    gotR = '0; gotCo = 1'b0; gotV = 1'b0;
    refModel(w, a, b, sub, er, eco, ev);
    @(negedge clk);
    driveInputs(use32, 1'b1, sub, a, b);
    for (int j = 0; j <= w + 1; j++) begin
      @(negedge clk);
      if (j == 0) driveInputs(use32, 1'b0, ~sub, $urandom, $urandom);
      if (obsBusy(use32)) busyCnt++;
      if (obsDone(use32)) begin
        doneCnt++;
        if (doneAt < 0) doneAt = j;
      end
      if (obsBusy(use32) && obsDone(use32)) both++;
      if (j == w) begin
        gotR = obsResult(use32); gotCo = obsCo(use32); gotV = obsV(use32);
        checkOutput({tag, ".result"}, 64'(gotR), 64'(er));
        checkOutput({tag, ".co"}, 64'(gotCo), 64'(eco));
        checkOutput({tag, ".v"}, 64'(gotV), 64'(ev));
      end
    end
    checkOutput({tag, ".busyCycles"}, 64'(busyCnt), 64'(w));
    checkOutput({tag, ".doneAt"}, 64'(doneAt), 64'(w));
    checkOutput({tag, ".doneCount"}, 64'(doneCnt), 64'd1);
    checkOutput({tag, ".busyDoneOverlap"}, 64'(both), 64'd0);
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic co, v;
    logic [31:0] ra, rb;
    logic rs;
    int doneSeen;

    // Reset state of both instances.
    #1;
    checkOutput("rst.busy8", 64'(busy8), 64'd0);
    checkOutput("rst.done8", 64'(done8), 64'd0);
    checkOutput("rst.res8", 64'(res8), 64'd0);
    checkOutput("rst.co8", 64'(co8), 64'd0);
    checkOutput("rst.v8", 64'(v8), 64'd0);
    checkOutput("rst.busy32", 64'(busy32), 64'd0);
    checkOutput("rst.res32", 64'(res32), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed 8-bit cases with hand-computed results.
    applyStimulus(1'b0, 32'h35, 32'h4A, 1'b0, "add35_4A", r, co, v);
    checkOutput("add35_4A.const", 64'({r, co, v}), 64'({32'h7F, 1'b0, 1'b0}));
    applyStimulus(1'b0, 32'hFF, 32'h01, 1'b0, "addFF_01", r, co, v);
    checkOutput("addFF_01.const", 64'({r, co, v}), 64'({32'h00, 1'b1, 1'b0}));
    applyStimulus(1'b0, 32'h7F, 32'h01, 1'b0, "add7F_01", r, co, v);
    checkOutput("add7F_01.const", 64'({r, co, v}), 64'({32'h80, 1'b0, 1'b1}));
    applyStimulus(1'b0, 32'h10, 32'h20, 1'b1, "sub10_20", r, co, v);
    checkOutput("sub10_20.const", 64'({r, co, v}), 64'({32'hF0, 1'b0, 1'b0}));
    applyStimulus(1'b0, 32'h80, 32'h01, 1'b1, "sub80_01", r, co, v);
    checkOutput("sub80_01.const", 64'({r, co, v}), 64'({32'h7F, 1'b1, 1'b1}));

    // Start held high: operand changes during RUN ignored, FIN start
    // ignored, re-acceptance exactly WIDTH+2 edges after the first.
    @(negedge clk);
    driveInputs(1'b0, 1'b1, 1'b0, 32'h11, 32'h22);
    for (int j = 0; j <= 18; j++) begin
      @(negedge clk);
      if (j == 8) begin
        checkOutput("hold.done1", 64'(done8), 64'd1);
        checkOutput("hold.res1", 64'(res8), 64'h33);
      end
      if (j == 9) begin
        checkOutput("hold.finIgnored", 64'(busy8), 64'd0);
        checkOutput("hold.idleDone", 64'(done8), 64'd0);
      end
      if (j == 10) checkOutput("hold.reaccept", 64'(busy8), 64'd1);
      if (j == 18) begin
        checkOutput("hold.done2", 64'(done8), 64'd1);
        checkOutput("hold.res2", 64'(res8), 64'h0B);
      end
      if (j == 9) driveInputs(1'b0, 1'b1, 1'b0, 32'h05, 32'h06);
      else if (j >= 10) driveInputs(1'b0, 1'b0, $urandom_range(0, 1), $urandom, $urandom);
      else driveInputs(1'b0, 1'b1, $urandom_range(0, 1), $urandom, $urandom);
    end
    @(negedge clk);

    // Asynchronous reset in the middle of a run, after an operation that
    // left CO and V set.
    applyStimulus(1'b0, 32'h80, 32'h01, 1'b1, "preRst", r, co, v);
    @(negedge clk);
    driveInputs(1'b0, 1'b1, 1'b0, 32'h3C, 32'h0F);
    @(negedge clk);
    driveInputs(1'b0, 1'b0, 1'b0, 32'h3C, 32'h0F);
    repeat (3) @(negedge clk);
    checkOutput("midRst.busyBefore", 64'(busy8), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRst.busy", 64'(busy8), 64'd0);
    checkOutput("midRst.done", 64'(done8), 64'd0);
    checkOutput("midRst.res", 64'(res8), 64'd0);
    checkOutput("midRst.co", 64'(co8), 64'd0);
    checkOutput("midRst.v", 64'(v8), 64'd0);
    doneSeen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done8) doneSeen++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) doneSeen++;
    end
    checkOutput("midRst.noDone", 64'(doneSeen), 64'd0);
    applyStimulus(1'b0, 32'h01, 32'h02, 1'b0, "postRst", r, co, v);
    checkOutput("postRst.const", 64'(r), 64'h03);

    // Random 8-bit operations.
    for (int n = 0; n < 200; n++) begin
      ra = $urandom & 32'hFF;
      rb = $urandom & 32'hFF;
      rs = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, ra, rb, rs, "rand8", r, co, v);
    end

    // Random 32-bit sweep, with a few corner operands mixed in.
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (n % 10 == 0) ra = 32'h8000_0000;
      if (n % 10 == 1) rb = 32'hFFFF_FFFF;
      if (n % 10 == 2) rb = ra;
      applyStimulus(1'b1, ra, rb, rs, "rand32", r, co, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
